// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response bus of the shared-ALU arbiter
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*OP_WIDTH-1:0]   req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_fault;
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_fault
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered-output ALU between NUM_REQ requesters
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_REQ    = 2,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_arbiter_if.slave          bus,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_in_a,
    output logic [DATA_WIDTH-1:0] alu_in_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_fault,
    output logic                  busy,
    output logic [FCNT_WIDTH-1:0] fault_cnt
);
    localparam int RW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
    state_t                state_q, state_d;
    logic [RW-1:0]         rr_q, rr_d, owner_q, owner_d, grant, idx;
    logic                  found;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [FCNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = RW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end
    // ready is gated by rst_n so nothing can be accepted while reset is held
    assign bus.req_ready = (rst_n && state_q == IDLE && found) ? NUM_REQ'(1) << grant : '0;
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        resp_valid_d = resp_valid_q;
        fault_cnt_d  = fault_cnt_q;
        case (state_q)
            IDLE: if (found) begin
                alu_op_d = bus.req_op[int'(grant)*OP_WIDTH +: OP_WIDTH];
                alu_a_d  = bus.req_a[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                alu_b_d  = bus.req_b[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                owner_d  = grant;
                rr_d     = (grant == RW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                state_d  = EXEC;
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                resp_fault_d = alu_fault;
                resp_data_d  = alu_fault ? '0 : alu_out;
                fault_cnt_d  = (alu_fault && !(&fault_cnt_q)) ? fault_cnt_q + 1'b1 : fault_cnt_q;
                resp_valid_d = NUM_REQ'(1) << owner_q;
                state_d      = RESP;
            end
            RESP: if (bus.resp_ready[owner_q]) begin
                resp_valid_d = '0;
                state_d      = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            owner_q      <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
            resp_valid_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            resp_valid_q <= resp_valid_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end
    assign alu_op         = alu_op_q;
    assign alu_in_a       = alu_a_q;
    assign alu_in_b       = alu_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_fault = resp_fault_q;
    assign fault_cnt      = fault_cnt_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with a behavioural one-cycle ALU
module tb_alu_arbiter;
    logic clk, rst_n;
    int checks = 0;
    int errors = 0;
    alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4), .NUM_REQ(2)) bus2 ();
    alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4), .NUM_REQ(3)) bus3 ();
    logic [3:0]  alu_op2, alu_op3;
    logic [31:0] a2, b2, a3, b3, alu_out2, alu_out3;
    logic        alu_fault2, alu_fault3, busy2, busy3;
    logic [7:0]  fcnt2, fcnt3;
    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .NUM_REQ(2), .FCNT_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .alu_op(alu_op2), .alu_in_a(a2), .alu_in_b(b2),
        .alu_out(alu_out2), .alu_fault(alu_fault2), .busy(busy2), .fault_cnt(fcnt2));
    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .NUM_REQ(3), .FCNT_WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .alu_op(alu_op3), .alu_in_a(a3), .alu_in_b(b3),
        .alu_out(alu_out3), .alu_fault(alu_fault3), .busy(busy3), .fault_cnt(fcnt3));
    // ops: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND, 10+ invalid
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return {31'd0, $signed(a) < $signed(b)};
            4'd4: return {31'd0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    always_ff @(posedge clk) begin
        alu_out2   <= alu_f(alu_op2, a2, b2);
        alu_fault2 <= alu_op2 >= 4'd10;
        alu_out3   <= alu_f(alu_op3, a3, b3);
        alu_fault3 <= alu_op3 >= 4'd10;
    end
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic set2(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus2.req_op[i*4 +: 4]  = op;
        bus2.req_a[i*32 +: 32] = a;
        bus2.req_b[i*32 +: 32] = b;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask
    task automatic wait_resp2(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus2.resp_valid != 2'b00) begin
                cyc = i;
                break;
            end
        end
    endtask
    task automatic test_reset();
        rst_n = 0;
        bus2.req_valid = 2'b11; bus2.resp_ready = 2'b11;
        bus2.req_op = '0; bus2.req_a = '0; bus2.req_b = '0;
        bus3.req_valid = 3'b000; bus3.resp_ready = 3'b111;
        bus3.req_op = '0; bus3.req_a = '0; bus3.req_b = '0;
        @(negedge clk); @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", bus2.req_ready); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy2); end
        checks++; if (bus2.resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got=%b exp=00", bus2.resp_valid); end
        checks++; if (fcnt2 !== 8'd0) begin errors++; $display("FAIL rst_fault_cnt got=%0d exp=0", fcnt2); end
        checks++; if ({alu_op2, a2, b2, bus2.resp_data, bus2.resp_fault} !== '0) begin errors++; $display("FAIL rst_regs got=%0h exp=0", {alu_op2, a2, b2, bus2.resp_data, bus2.resp_fault}); end
        bus2.req_valid = 2'b00;
        rst_n = 1;
    endtask
    task automatic test_single();
        int cyc;
        @(negedge clk);
        set2(0, 4'd0, 32'd5, 32'd7);
        bus2.req_valid = 2'b01;
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus2.req_ready); end
        @(negedge clk);
        bus2.req_valid = 2'b00;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy_exec got=%b exp=1", busy2); end
        checks++; if ({alu_op2, a2, b2} !== {4'd0, 32'd5, 32'd7}) begin errors++; $display("FAIL single_alu_in got=%0h exp=%0h", {alu_op2, a2, b2}, {4'd0, 32'd5, 32'd7}); end
        wait_resp2(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", cyc); end
        checks++; if (bus2.resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid got=%b exp=01", bus2.resp_valid); end
        checks++; if (bus2.resp_data !== 32'd12) begin errors++; $display("FAIL single_data got=%0d exp=12", bus2.resp_data); end
        checks++; if (bus2.resp_fault !== 1'b0) begin errors++; $display("FAIL single_fault got=%b exp=0", bus2.resp_fault); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy_resp got=%b exp=1", busy2); end
        @(negedge clk);
        checks++; if (busy2 !== 1'b0 || bus2.resp_valid !== 2'b00) begin errors++; $display("FAIL single_done got=%b%b exp=000", busy2, bus2.resp_valid); end
    endtask
    task automatic test_rotation();
        int cyc, g;
        logic [1:0] e;
        do_reset();
        set2(0, 4'd1, 32'd10, 32'd3);
        set2(1, 4'd4, 32'd1, 32'd2);
        bus2.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            e = (g == 0) ? 2'b01 : 2'b10;
            checks++; if (bus2.req_ready !== e) begin errors++; $display("FAIL rot_grant%0d got=%b exp=%b", k, bus2.req_ready, e); end
            wait_resp2(cyc);
            checks++; if (bus2.resp_valid !== e) begin errors++; $display("FAIL rot_resp_valid%0d got=%b exp=%b", k, bus2.resp_valid, e); end
            checks++; if (bus2.resp_data !== ((g == 0) ? 32'd7 : 32'd1)) begin errors++; $display("FAIL rot_data%0d got=%0d exp=%0d", k, bus2.resp_data, (g == 0) ? 7 : 1); end
            @(negedge clk);
        end
        bus2.req_valid = 2'b00;
    endtask
    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        bus2.resp_ready = 2'b00;
        set2(0, 4'd0, 32'd3, 32'd4);
        bus2.req_valid = 2'b01;
        wait_resp2(cyc);
        checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 32'd7) begin errors++; $display("FAIL bp_first got=%b/%0d exp=01/7", bus2.resp_valid, bus2.resp_data); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 32'd7) begin errors++; $display("FAIL bp_hold%0d got=%b/%0d exp=01/7", i, bus2.resp_valid, bus2.resp_data); end
            checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got=%b exp=00", i, bus2.req_ready); end
        end
        bus2.resp_ready = 2'b10;
        @(negedge clk); @(negedge clk);
        checks++; if (bus2.resp_valid !== 2'b01 || busy2 !== 1'b1) begin errors++; $display("FAIL bp_nonowner got=%b/%b exp=01/1", bus2.resp_valid, busy2); end
        bus2.resp_ready = 2'b11;
        @(negedge clk);
        checks++; if (bus2.resp_valid !== 2'b00 || busy2 !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=00/0", bus2.resp_valid, busy2); end
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_ready got=%b exp=01", bus2.req_ready); end
        bus2.req_valid = 2'b00;
        @(negedge clk);
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL bp_no_accept got=%b exp=0", busy2); end
    endtask
    task automatic test_fault();
        int cyc;
        set2(1, 4'd10, 32'd9, 32'd9);
        bus2.req_valid = 2'b10;
        wait_resp2(cyc);
        checks++; if (bus2.resp_valid !== 2'b10) begin errors++; $display("FAIL fault_resp_valid got=%b exp=10", bus2.resp_valid); end
        checks++; if (bus2.resp_fault !== 1'b1 || bus2.resp_data !== 32'd0) begin errors++; $display("FAIL fault_data got=%b/%0h exp=1/0", bus2.resp_fault, bus2.resp_data); end
        checks++; if (fcnt2 !== 8'd1) begin errors++; $display("FAIL fault_cnt1 got=%0d exp=1", fcnt2); end
        for (int i = 2; i <= 300; i++) begin
            wait_resp2(cyc);
            if (i == 2 || i == 254 || i == 255) begin
                checks++; if (cyc !== 4) begin errors++; $display("FAIL fault_spacing%0d got=%0d exp=4", i, cyc); end
            end
            if (i == 254) begin
                checks++; if (fcnt2 !== 8'd254) begin errors++; $display("FAIL fault_cnt254 got=%0d exp=254", fcnt2); end
            end
            if (i == 255) begin
                checks++; if (fcnt2 !== 8'd255) begin errors++; $display("FAIL fault_cnt255 got=%0d exp=255", fcnt2); end
            end
        end
        checks++; if (fcnt2 !== 8'd255) begin errors++; $display("FAIL fault_sat got=%0d exp=255", fcnt2); end
        checks++; if (bus2.resp_data !== 32'd0 || bus2.resp_fault !== 1'b1) begin errors++; $display("FAIL fault_last got=%b/%0h exp=1/0", bus2.resp_fault, bus2.resp_data); end
        bus2.req_valid = 2'b00;
    endtask
    task automatic test_reset_mid();
        int cyc;
        int seen = 0;
        @(negedge clk);
        set2(0, 4'd5, 32'hF0, 32'hFF);
        bus2.req_valid = 2'b01;
        @(negedge clk);
        bus2.req_valid = 2'b00;
        checks++; if (busy2 !== 1'b1 || alu_op2 !== 4'd5) begin errors++; $display("FAIL mid_exec got=%b/%0d exp=1/5", busy2, alu_op2); end
        rst_n = 0;
        #1;
        checks++; if (busy2 !== 1'b0 || fcnt2 !== 8'd0) begin errors++; $display("FAIL mid_async got=%b/%0d exp=0/0", busy2, fcnt2); end
        checks++; if ({alu_op2, a2, b2, bus2.resp_data, bus2.resp_fault, bus2.resp_valid} !== '0) begin errors++; $display("FAIL mid_regs got=%0h exp=0", {alu_op2, a2, b2, bus2.resp_data}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus2.resp_valid !== 2'b00 || busy2 !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_resp got=%0d exp=0", seen); end
        set2(0, 4'd0, 32'd1, 32'd2);
        set2(1, 4'd0, 32'd8, 32'd8);
        bus2.req_valid = 2'b11;
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL mid_rr0 got=%b exp=01", bus2.req_ready); end
        @(negedge clk);
        bus2.req_valid = 2'b00;
        wait_resp2(cyc);
        checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 32'd3) begin errors++; $display("FAIL mid_next got=%b/%0d exp=01/3", bus2.resp_valid, bus2.resp_data); end
        @(negedge clk);
    endtask
    task automatic test_three();
        int cyc;
        int exp_g[4] = '{0, 1, 2, 0};
        logic [2:0] e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus3.req_op[i*4 +: 4]  = 4'd2;
            bus3.req_a[i*32 +: 32] = 32'd1;
            bus3.req_b[i*32 +: 32] = 32'd4;
        end
        bus3.req_valid = 3'b111;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = 3'(1 << exp_g[k]);
            checks++; if (bus3.req_ready !== e) begin errors++; $display("FAIL three_grant%0d got=%b exp=%b", k, bus3.req_ready, e); end
            cyc = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (bus3.resp_valid != 3'b000) begin
                    cyc = i;
                    break;
                end
            end
            checks++; if (cyc < 0) begin errors++; $display("FAIL three_timeout%0d got=%0d exp=3", k, cyc); end
            checks++; if (bus3.resp_valid !== e || bus3.resp_data !== 32'd16) begin errors++; $display("FAIL three_resp%0d got=%b/%0d exp=%b/16", k, bus3.resp_valid, bus3.resp_data, e); end
            @(negedge clk);
        end
        bus3.req_valid = 3'b000;
    endtask
    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_fault();
        test_reset_mid();
        test_three();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one registered-output ALU instance between NUM_REQ independent requesters, such as a decode stage and a debug/CSR port.
- Round-robin arbitration picks one request at a time.
- The selected op and operands are registered onto the ALU input bus, and the ALU result is captured after its one-cycle latency.
- The result is held for the granted requester under a valid/ready handshake.
- Invalid-op faults are counted.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, ALU op code width
NUM_REQ, 2, number of requesters (>=2)
FCNT_WIDTH, 8, width of saturating fault counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_op  in  NUM_REQ*OP_WIDTH  packed ops, requester i at [i*OP_WIDTH +: OP_WIDTH]
req_a  in  NUM_REQ*DATA_WIDTH  packed operand A
req_b  in  NUM_REQ*DATA_WIDTH  packed operand B
resp_valid  out  NUM_REQ  one-hot result valid to the owning requester
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  DATA_WIDTH  captured result
resp_fault  out  1  captured ALU fault
alu_op  out  OP_WIDTH  registered op to ALU
alu_in_a  out  DATA_WIDTH  registered operand A to ALU
alu_in_b  out  DATA_WIDTH  registered operand B to ALU
alu_out  in  DATA_WIDTH  ALU result, registered inside ALU (1-cycle latency)
alu_fault  in  1  ALU invalid-op flag, same timing as alu_out
busy  out  1  high in any state other than IDLE
fault_cnt  out  FCNT_WIDTH  count of faulted ops, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; rr pointer 0; alu_op/alu_in_a/alu_in_b 0.
  - resp_valid 0, resp_data 0, resp_fault 0, fault_cnt 0.
  - req_ready is forced 0 while rst_n is low.
  - Reset mid-operation drops the in-flight op with no response. An ALU result arriving after reset is ignored.
- States: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - Grant = first i with req_valid[i], searching from the rr pointer upward modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally; all other bits 0. No valid requests -> req_ready all 0.
  - On an edge with req_valid[g] & req_ready[g]:
    - alu_op/alu_in_a/alu_in_b <= requester g fields; owner <= g.
    - rr pointer <= (g+1) mod NUM_REQ.
    - state <= EXEC.
- EXEC: the ALU samples the held inputs at this edge; state <= CAPT.
- CAPT:
  - resp_fault <= alu_fault.
  - resp_data <= alu_fault ? 0 : alu_out. This hides the ALU's undefined output on a fault.
  - If alu_fault, fault_cnt increments, saturating at all-ones.
  - state <= RESP.
- RESP:
  - resp_valid[owner] = 1; all other bits 0.
  - resp_data, resp_fault and the ALU input registers are held stable.
  - On an edge with resp_ready[owner]: resp_valid <= 0, state <= IDLE.
  - resp_ready on non-owner bits is ignored.
- Timing: accept at edge N -> resp_valid high after edge N+2. Earliest next accept is the cycle after the response handshake. Minimum spacing is 4 cycles per op.
- req_ready is 0 in EXEC, CAPT and RESP. Requesters hold req_valid and fields until accepted, but the arbiter does not depend on this.
- A requester whose req_valid drops before accept is simply not granted. A one-cycle pulse is legal if accepted in that cycle.
- Simultaneous requests from all requesters are served in strict rotation. No requester waits more than NUM_REQ-1 grants.
- The ALU input registers keep their last values in IDLE; they are not cleared after an op.
- busy = (state != IDLE).

Test Plan:
- Reset, then req0 op=0000 a=5 b=7 valid one cycle -> req_ready[0]=1 that cycle, resp_valid=2'b01 two edges later, resp_data=12, resp_fault=0, busy 1 throughout.
- req0 and req1 held valid after reset: req0 SUB 10-3, req1 SLTU 1<2 -> grants in order 0,1,0,1; responses 7 to req0 and 1 to req1; no double grant.
- req1 op=1010 -> resp_valid=2'b10, resp_fault=1, resp_data=0, fault_cnt=1. Repeat 300 times -> fault_cnt saturates at 255.
- Backpressure: resp_ready held 0 for 5 cycles in RESP with req0 valid -> resp_data stable, req_ready=0; resp_ready[1] asserted while owner=0 -> no effect.
- Assert rst_n low during EXEC of an XOR -> all outputs go to reset values immediately, no resp_valid follows, next request is served normally with rr pointer 0.
- NUM_REQ=3 build, all valid, ALU ops SLL 1<<4 -> grants 0,1,2,0, each resp_data=16.
